high_score_tracker: RTL and testbench

Downstream consumer of the single-player match game's round events.
- Counts points for the current game as a BCD score; the score saturates at 99.
- Keeps the best score seen since reset.
- Flashes a new-record LED when a finished game beats the best score.
- Inputs are the shaped correct-answer pulse, the timer reconfigure pulse (game start) and the ones-digit borrow (time-out). BCD outputs drive the existing Decoder7Seg instances.

---
 rtl/high_score_tracker.sv | 191 +++++++++++++++++++
 tb/tb_high_score_tracker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/high_score_tracker.sv
// rtl/high_score_tracker.sv - BCD game score, best-score keeper and new-record blinker
//
// Counts points of the running game as a two-digit BCD score (saturating at 99),
// keeps the best finished-game score since reset, and blinks NEW_RECORD when a
// finished game strictly beats the best score.
//
// Optional feature macro: BEST_CLEAR_EN (adds CLEAR_BEST input; clears best in IDLE).
//
// Ports:
//   CLK          system clock, posedge
//   RST          asynchronous active-low reset
//   GAME_START   one-cycle pulse, new game begins / restarts
//   GAME_OVER    one-cycle pulse, game timer expired
//   POINT        one-cycle pulse, correct answer scored
//   CLEAR_BEST   (BEST_CLEAR_EN only) one-cycle pulse, clear best score while idle
//   SCORE_TENS   BCD tens of current / last game score
//   SCORE_ONES   BCD ones of current / last game score
//   BEST_TENS    BCD tens of best score
//   BEST_ONES    BCD ones of best score
//   GAME_ACTIVE  high while a game is being played
//   NEW_RECORD   blinking record indicator
module high_score_tracker #(
    parameter int BLINK_CYCLES  = 25000000,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       GAME_START,
    input  logic       GAME_OVER,
    input  logic       POINT,
`ifdef BEST_CLEAR_EN
    input  logic       CLEAR_BEST,
`endif
    output logic [3:0] SCORE_TENS,
    output logic [3:0] SCORE_ONES,
    output logic [3:0] BEST_TENS,
    output logic [3:0] BEST_ONES,
    output logic       GAME_ACTIVE,
    output logic       NEW_RECORD
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(BLINK_TOGGLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        CHECK     = 2'd2,
        CELEBRATE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    score_tens_q, score_tens_d;
    logic [3:0]    score_ones_q, score_ones_d;
    logic [3:0]    best_tens_q, best_tens_d;
    logic [3:0]    best_ones_q, best_ones_d;
    logic          game_active_q, game_active_d;
    logic          new_record_q, new_record_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [TW-1:0] toggle_cnt_q, toggle_cnt_d;

    logic          clear_best;
    logic [TW-1:0] toggle_inc;

    always_comb begin
        state_d      = state_q;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;
        best_tens_d  = best_tens_q;
        best_ones_d  = best_ones_q;
        new_record_d = new_record_q;
        blink_cnt_d  = blink_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        toggle_inc   = toggle_cnt_q + TW'(1);
        clear_best   = 1'b0;
`ifdef BEST_CLEAR_EN
        clear_best   = CLEAR_BEST;
`endif

        case (state_q)
            IDLE: begin
                if (clear_best) begin
                    best_tens_d = 4'd0;
                    best_ones_d = 4'd0;
                end
                if (GAME_START) begin
                    score_tens_d = 4'd0;
                    score_ones_d = 4'd0;
                    state_d      = PLAY;
                end
            end

            PLAY: begin
                // A restart takes priority over the timer expiring in the same cycle.
                if (GAME_START) begin
                    score_tens_d = 4'd0;
                    score_ones_d = 4'd0;
                end else begin
                    if (POINT && !(score_tens_q == 4'd9 && score_ones_q == 4'd9)) begin
                        if (score_ones_q == 4'd9) begin
                            score_ones_d = 4'd0;
                            score_tens_d = score_tens_q + 4'd1;
                        end else begin
                            score_ones_d = score_ones_q + 4'd1;
                        end
                    end
                    if (GAME_OVER) begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                // Packed BCD digits compare in the same order as their decimal values.
                if ({score_tens_q, score_ones_q} > {best_tens_q, best_ones_q}) begin
                    best_tens_d  = score_tens_q;
                    best_ones_d  = score_ones_q;
                    new_record_d = 1'b1;
                    blink_cnt_d  = '0;
                    toggle_cnt_d = TW'(1);
                    state_d      = CELEBRATE;
                end else begin
                    state_d = IDLE;
                end
            end

            CELEBRATE: begin
                if (GAME_START) begin
                    new_record_d = 1'b0;
                    blink_cnt_d  = '0;
                    toggle_cnt_d = '0;
                    score_tens_d = 4'd0;
                    score_ones_d = 4'd0;
                    state_d      = PLAY;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d  = '0;
                    toggle_cnt_d = toggle_inc;
                    // The rising edge at entry is toggle 1, so the final toggle lands low.
                    if (toggle_inc == TOGGLE_LAST) begin
                        new_record_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        new_record_d = ~new_record_q;
                    end
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        game_active_d = (state_d == PLAY);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            score_tens_q  <= 4'd0;
            score_ones_q  <= 4'd0;
            best_tens_q   <= 4'd0;
            best_ones_q   <= 4'd0;
            game_active_q <= 1'b0;
            new_record_q  <= 1'b0;
            blink_cnt_q   <= '0;
            toggle_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            score_tens_q  <= score_tens_d;
            score_ones_q  <= score_ones_d;
            best_tens_q   <= best_tens_d;
            best_ones_q   <= best_ones_d;
            game_active_q <= game_active_d;
            new_record_q  <= new_record_d;
            blink_cnt_q   <= blink_cnt_d;
            toggle_cnt_q  <= toggle_cnt_d;
        end
    end

    assign SCORE_TENS  = score_tens_q;
    assign SCORE_ONES  = score_ones_q;
    assign BEST_TENS   = best_tens_q;
    assign BEST_ONES   = best_ones_q;
    assign GAME_ACTIVE = game_active_q;
    assign NEW_RECORD  = new_record_q;

endmodule

// File: tb/tb_high_score_tracker.sv
// tb/tb_high_score_tracker.sv - self-checking bench for high_score_tracker
module tb_high_score_tracker;

    localparam int BC = 4;
    localparam int BT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_start = 1'b0;
    logic       game_over = 1'b0;
    logic       point = 1'b0;
`ifdef BEST_CLEAR_EN
    logic       clear_best = 1'b0;
`endif
    logic [3:0] score_tens, score_ones, best_tens, best_ones;
    logic       game_active, new_record;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain integers. mode 0=idle 1=play 2=check 3=celebrate.
    int m_mode, m_score, m_best, m_t;

    always #5 clk = ~clk;

    high_score_tracker #(
        .BLINK_CYCLES (BC),
        .BLINK_TOGGLES(BT)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .GAME_START (game_start),
        .GAME_OVER  (game_over),
        .POINT      (point),
`ifdef BEST_CLEAR_EN
        .CLEAR_BEST (clear_best),
`endif
        .SCORE_TENS (score_tens),
        .SCORE_ONES (score_ones),
        .BEST_TENS  (best_tens),
        .BEST_ONES  (best_ones),
        .GAME_ACTIVE(game_active),
        .NEW_RECORD (new_record)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_score = 0;
        m_best  = 0;
        m_t     = 0;
    endtask

    task automatic model_step(input bit s, input bit o, input bit p, input bit c);
        case (m_mode)
            0: begin
`ifdef BEST_CLEAR_EN
                if (c) m_best = 0;
`endif
                if (s) begin
                    m_score = 0;
                    m_mode  = 1;
                end
            end
            1: begin
                if (s) begin
                    m_score = 0;
                end else begin
                    if (p && m_score < 99) m_score++;
                    if (o) m_mode = 2;
                end
            end
            2: begin
                if (m_score > m_best) begin
                    m_best = m_score;
                    m_mode = 3;
                    m_t    = 0;
                end else begin
                    m_mode = 0;
                end
            end
            default: begin
                if (s) begin
                    m_score = 0;
                    m_mode  = 1;
                end else begin
                    m_t++;
                    if (m_t == BC * (BT - 1)) m_mode = 0;
                end
            end
        endcase
    endtask

    function automatic logic [17:0] model_outputs();
        logic [3:0] st, so, bt, bo;
        logic       ga, nr;
        st = 4'(m_score / 10);
        so = 4'(m_score % 10);
        bt = 4'(m_best / 10);
        bo = 4'(m_best % 10);
        ga = (m_mode == 1);
        nr = (m_mode == 3) && (((m_t / BC) % 2) == 0);
        return {st, so, bt, bo, ga, nr};
    endfunction

    task automatic check_outputs(input string tag);
        check_eq(tag, {14'd0, score_tens, score_ones, best_tens, best_ones, game_active, new_record},
                 {14'd0, model_outputs()});
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, then sample at the next negedge.
    task automatic cycle(input bit s, input bit o, input bit p, input bit c);
        game_start = s;
        game_over  = o;
        point      = p;
`ifdef BEST_CLEAR_EN
        clear_best = c;
`endif
        @(posedge clk);
        model_step(s, o, p, c);
        @(negedge clk);
        game_start = 1'b0;
        game_over  = 1'b0;
        point      = 1'b0;
`ifdef BEST_CLEAR_EN
        clear_best = 1'b0;
`endif
        check_outputs("cycle");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs("reset");
    endtask

    task automatic play_game(input int pts);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < pts; i++) cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        int toggles;
        logic prev_nr;

        // 1. reset and idle
        do_reset();
        check_eq("t1_reset_all", {best_tens, best_ones, score_tens, score_ones, game_active, new_record}, 0);
        cycle(0, 1, 0, 0);
        idle_cycles(2);
        check_eq("t1_over_in_idle", {best_tens, best_ones, score_tens, score_ones, game_active, new_record}, 0);

        // 2. BCD counting and saturation
        cycle(1, 0, 0, 0);
        check_eq("t2_active", game_active, 1);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0);
        check_eq("t2_score12", {score_tens, score_ones}, 8'h12);
        for (int i = 12; i < 105; i++) cycle(0, 0, 1, 0);
        check_eq("t2_score99", {score_tens, score_ones}, 8'h99);
        do_reset();

        // 3. first record and blink
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        check_eq("t3_nr_not_yet", new_record, 0);
        cycle(0, 0, 0, 0);
        check_eq("t3_best07", {best_tens, best_ones}, 8'h07);
        check_eq("t3_nr_rise", new_record, 1);
        toggles = 1;
        prev_nr = new_record;
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 0);
            if (new_record != prev_nr) toggles++;
            prev_nr = new_record;
        end
        check_eq("t3_toggles", toggles, 6);
        check_eq("t3_nr_end", new_record, 0);

        // 4. tie and loss
        play_game(7);
        play_game(5);
        idle_cycles(3);
        check_eq("t4_best07", {best_tens, best_ones}, 8'h07);
        check_eq("t4_nr0", new_record, 0);
        check_eq("t4_score05", {score_tens, score_ones}, 8'h05);

        // 5. simultaneous events
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        check_eq("t5_best08", {best_tens, best_ones}, 8'h08);
        idle_cycles(25);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 0);
        check_eq("t5_restart_score", {score_tens, score_ones}, 8'h00);
        idle_cycles(2);
        check_eq("t5_still_active", game_active, 1);
        check_eq("t5_best_kept", {best_tens, best_ones}, 8'h08);
        cycle(0, 1, 0, 0);
        idle_cycles(2);

        // 6. abort during celebrate, then async reset mid-play
        play_game(9);
        check_eq("t6_best09", {best_tens, best_ones}, 8'h09);
        idle_cycles(5);
        cycle(1, 0, 0, 0);
        check_eq("t6_abort", {score_tens, score_ones, game_active, new_record}, 10'b0000_0000_10);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_eq("t6_async_rst", {best_tens, best_ones, score_tens, score_ones, game_active, new_record}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BEST_CLEAR_EN
        play_game(3);
        idle_cycles(25);
        check_eq("t6_best03", {best_tens, best_ones}, 8'h03);
        cycle(0, 0, 0, 1);
        check_eq("t6_clear_best", {best_tens, best_ones}, 8'h00);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
